// File: rtl/soc_ifc_fuse_loader.sv
// soc_ifc_fuse_loader: streams fuses into Caliptra, releases the boot breakpoint and drives firmware-update resets
module soc_ifc_fuse_loader #(
  parameter int unsigned NUM_FUSE_WORDS = 32,
  parameter logic [31:0] FUSE_BASE_ADDR = 32'h0000_0200,
  parameter logic [31:0] FUSE_DONE_ADDR = 32'h0000_00AC,
  parameter logic [31:0] CONTINUE_ADDR  = 32'h0000_00BC,
  parameter logic [31:0] FW_UPD_ADDR    = 32'h0000_0070,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  localparam int unsigned IW = (NUM_FUSE_WORDS > 1) ? $clog2(NUM_FUSE_WORDS) : 1
) (
  input  logic          clk,
  input  logic          cptra_rst_b,
  input  logic          ready_for_fuses,
  output logic          src_rd_en,
  output logic [IW-1:0] src_rd_idx,
  input  logic [31:0]   src_rd_data,
  output logic          wr_req,
  output logic [31:0]   wr_addr,
  output logic [31:0]   wr_data,
  input  logic          wr_ack,
  input  logic          wr_err,
  input  logic          brkpt_en,
  input  logic          continue_req,
  input  logic          fw_upd_req,
  input  logic          uc_rst_b,
  output logic          busy,
  output logic          boot_done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [7:0]    fw_upd_count
);
  typedef enum logic [3:0] {
    IDLE, READ, WRITE, DONE_WR, BRK_WAIT, GO_WR, WAIT_UC, RUN, FWU_WR, FWU_LO, FWU_HI, ERROR
  } state_e;
  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          src_rd_en_q, src_rd_en_d, wr_req_q, wr_req_d;
  logic [31:0]   wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic          busy_q, busy_d, boot_done_q, boot_done_d, err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    fw_upd_count_q, fw_upd_count_d;
  logic          ack, is_wr, counting, tmo, last;
  always_comb begin
    ack      = wr_req_q & wr_ack;
    is_wr    = state_q inside {WRITE, DONE_WR, GO_WR, FWU_WR};
    counting = is_wr ? (wr_req_q & ~wr_ack) : (state_q inside {WAIT_UC, FWU_LO, FWU_HI});
    tmo      = counting && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    last     = idx_q == IW'(NUM_FUSE_WORDS - 1);
    case (state_q)
      IDLE:     state_d = ready_for_fuses ? READ : IDLE;
      READ:     state_d = WRITE;
      WRITE:    state_d = ack ? (last ? DONE_WR : READ) : WRITE;
      DONE_WR:  state_d = ack ? (brkpt_en ? BRK_WAIT : WAIT_UC) : DONE_WR;
      BRK_WAIT: state_d = continue_req ? GO_WR : (brkpt_en ? BRK_WAIT : WAIT_UC);
      GO_WR:    state_d = ack ? WAIT_UC : GO_WR;
      WAIT_UC:  state_d = uc_rst_b ? RUN : WAIT_UC;
      RUN:      state_d = fw_upd_req ? FWU_WR : RUN;
      FWU_WR:   state_d = ack ? FWU_LO : FWU_WR;
      FWU_LO:   state_d = uc_rst_b ? FWU_LO : FWU_HI;
      FWU_HI:   state_d = uc_rst_b ? RUN : FWU_HI;
      default:  state_d = ERROR;
    endcase
    if ((ack && wr_err) || (tmo && state_d == state_q)) state_d = ERROR;
    err_code_d     = (state_d == ERROR && state_q != ERROR) ? ((ack && wr_err) ? 2'd1 : is_wr ? 2'd2 : 2'd3) : err_code_q;
    idx_d          = (state_q == IDLE) ? '0 : (state_q == WRITE && state_d == READ) ? idx_q + 1'b1 : idx_q;
    cnt_d          = (state_d != state_q) ? 16'd0 : counting ? cnt_q + 16'd1 : cnt_q;
    wr_req_d       = (state_d inside {WRITE, DONE_WR, GO_WR, FWU_WR}) && !ack;
    wr_addr_d      = (state_q == READ) ? FUSE_BASE_ADDR + (32'(idx_q) << 2) :
                     (state_d == state_q) ? wr_addr_q :
                     (state_d == DONE_WR) ? FUSE_DONE_ADDR :
                     (state_d == GO_WR) ? CONTINUE_ADDR :
                     (state_d == FWU_WR) ? FW_UPD_ADDR : wr_addr_q;
    wr_data_d      = (state_q == READ) ? src_rd_data :
                     (state_d != state_q && (state_d inside {DONE_WR, GO_WR, FWU_WR})) ? 32'h1 : wr_data_q;
    src_rd_en_d    = state_d == READ;
    busy_d         = !(state_d inside {IDLE, RUN, ERROR});
    boot_done_d    = boot_done_q | (state_d == RUN);
    err_d          = state_d == ERROR;
    fw_upd_count_d = (state_q == FWU_HI && state_d == RUN && fw_upd_count_q != 8'hFF) ? fw_upd_count_q + 8'd1 : fw_upd_count_q;
  end
  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      cnt_q          <= '0;
      src_rd_en_q    <= 1'b0;
      wr_req_q       <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      busy_q         <= 1'b0;
      boot_done_q    <= 1'b0;
      err_q          <= 1'b0;
      err_code_q     <= '0;
      fw_upd_count_q <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      src_rd_en_q    <= src_rd_en_d;
      wr_req_q       <= wr_req_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      busy_q         <= busy_d;
      boot_done_q    <= boot_done_d;
      err_q          <= err_d;
      err_code_q     <= err_code_d;
      fw_upd_count_q <= fw_upd_count_d;
    end
  end
  assign src_rd_en    = src_rd_en_q;
  assign src_rd_idx   = idx_q;
  assign wr_req       = wr_req_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = busy_q;
  assign boot_done    = boot_done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;
  assign fw_upd_count = fw_upd_count_q;
endmodule

// File: tb/tb_soc_ifc_fuse_loader.sv
// tb_soc_ifc_fuse_loader: scoreboard bench for the fuse loader write stream, breakpoint, fw-update and error paths
module tb_soc_ifc_fuse_loader;
  localparam int NW = 4;
  localparam int TO = 64;
  localparam logic [31:0] A_BASE = 32'h200;
  localparam logic [31:0] A_DONE = 32'hAC;
  localparam logic [31:0] A_CONT = 32'hBC;
  localparam logic [31:0] A_FWU  = 32'h70;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;
  logic        clk = 1'b0;
  logic        cptra_rst_b, ready_for_fuses, src_rd_en, wr_req, wr_ack, wr_err;
  logic        brkpt_en, continue_req, fw_upd_req, uc_rst_b, busy, boot_done, err;
  logic [1:0]  src_rd_idx, err_code;
  logic [31:0] src_rd_data, wr_addr, wr_data;
  logic [7:0]  fw_upd_count;
  int          n_cmp = 0, n_fail = 0;
  int          stall_max = 0, err_at = 0;
  logic        no_ack = 1'b0;
  wr_t         exp_q[$];
  int          cyc = 0, last_ack = -10, stall_left = 0, ack_num = 0, exp_rd_idx = 0;
  logic        in_xfer = 1'b0;
  logic [31:0] hold_a, hold_d;
  soc_ifc_fuse_loader #(.NUM_FUSE_WORDS(NW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .cptra_rst_b(cptra_rst_b), .ready_for_fuses(ready_for_fuses),
    .src_rd_en(src_rd_en), .src_rd_idx(src_rd_idx), .src_rd_data(src_rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
    .brkpt_en(brkpt_en), .continue_req(continue_req), .fw_upd_req(fw_upd_req), .uc_rst_b(uc_rst_b),
    .busy(busy), .boot_done(boot_done), .err(err), .err_code(err_code), .fw_upd_count(fw_upd_count)
  );
  always #5 clk = ~clk;
  assign src_rd_data = 32'hA0 + 32'(src_rd_idx);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask
  task automatic push_stream(input int n);
    for (int i = 0; i < n; i++) push_wr(A_BASE + 32'(4 * i), 32'hA0 + 32'(i));
  endtask
  task automatic cyc1();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      cyc1();
      n++;
    end
    chk(name, 32'(exp_q.size()), 0);
  endtask
  task automatic count_to_err(input string name, input int exp_n);
    int n = 0;
    while (!err && n < exp_n + 10) begin
      cyc1();
      n++;
    end
    chk(name, 32'(n), 32'(exp_n));
  endtask
  task automatic chk_zero(input string pfx);
    chk({pfx, "_src_rd_en"}, 32'(src_rd_en), 0);
    chk({pfx, "_src_rd_idx"}, 32'(src_rd_idx), 0);
    chk({pfx, "_wr_req"}, 32'(wr_req), 0);
    chk({pfx, "_wr_addr"}, wr_addr, 0);
    chk({pfx, "_wr_data"}, wr_data, 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_boot_done"}, 32'(boot_done), 0);
    chk({pfx, "_err"}, 32'(err), 0);
    chk({pfx, "_err_code"}, 32'(err_code), 0);
    chk({pfx, "_fw_upd_count"}, 32'(fw_upd_count), 0);
  endtask
  task automatic apply_reset();
    cptra_rst_b = 1'b0;
    ready_for_fuses = 1'b0;
    fw_upd_req = 1'b0;
    continue_req = 1'b0;
    exp_q.delete();
    repeat (2) cyc1();
    cptra_rst_b = 1'b1;
  endtask
  task automatic pulse_rff();
    ready_for_fuses = 1'b1;
    cyc1();
    ready_for_fuses = 1'b0;
  endtask
  initial forever begin
    @(negedge clk);
    cyc++;
    wr_ack = 1'b0;
    wr_err = 1'b0;
    if (!cptra_rst_b) begin
      ack_num = 0;
      stall_left = 0;
      in_xfer = 1'b0;
      last_ack = -10;
      exp_rd_idx = 0;
    end else begin
      if (wr_req && !no_ack) begin
        if (stall_left > 0) stall_left--;
        else begin
          wr_ack = 1'b1;
          ack_num++;
          wr_err = (ack_num == err_at);
          stall_left = int'($urandom_range(stall_max, 0));
        end
      end
      if (src_rd_en) begin
        chk("rd_idx", 32'(src_rd_idx), 32'(exp_rd_idx));
        exp_rd_idx++;
      end
      if (err) chk("wr_req_in_error", 32'(wr_req), 0);
      if (wr_req) begin
        if (!in_xfer) begin
          chk("wr_gap_ge2", 32'(cyc - last_ack >= 2), 1);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_wr: addr %h data %h, required no write", wr_addr, wr_data);
          end else begin
            chk("wr_addr", wr_addr, exp_q[0].a);
            chk("wr_data", wr_data, exp_q[0].d);
          end
          hold_a = wr_addr;
          hold_d = wr_data;
          in_xfer = 1'b1;
        end else begin
          chk("wr_addr_stable", wr_addr, hold_a);
          chk("wr_data_stable", wr_data, hold_d);
        end
        if (wr_ack) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          in_xfer = 1'b0;
          last_ack = cyc;
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
  initial begin
    cptra_rst_b = 1'b0;
    ready_for_fuses = 1'b0;
    brkpt_en = 1'b0;
    continue_req = 1'b0;
    fw_upd_req = 1'b0;
    uc_rst_b = 1'b0;
    repeat (3) cyc1();
    chk_zero("reset");
    cptra_rst_b = 1'b1;
    cyc1();
    chk("idle_busy", 32'(busy), 0);
    push_stream(NW);
    push_wr(A_DONE, 32'h1);
    pulse_rff();
    chk("t1_src_rd_en", 32'(src_rd_en), 1);
    chk("t1_wr_req", 32'(wr_req), 0);
    chk("t1_busy", 32'(busy), 1);
    cyc1();
    chk("t2_wr_req", 32'(wr_req), 1);
    chk("t2_wr_addr", wr_addr, 32'h200);
    chk("t2_wr_data", wr_data, 32'hA0);
    chk("t2_src_rd_en", 32'(src_rd_en), 0);
    wait_drain("drain_boot", 40);
    cyc1();
    chk("wait_uc_busy", 32'(busy), 1);
    chk("wait_uc_wr_req", 32'(wr_req), 0);
    uc_rst_b = 1'b1;
    chk("boot_done_before", 32'(boot_done), 0);
    cyc1();
    chk("boot_done", 32'(boot_done), 1);
    chk("run_busy", 32'(busy), 0);
    push_wr(A_FWU, 32'h1);
    fw_upd_req = 1'b1;
    cyc1();
    fw_upd_req = 1'b0;
    chk("fwu_busy", 32'(busy), 1);
    wait_drain("drain_fwu", 20);
    repeat (2) cyc1();
    fw_upd_req = 1'b1;
    cyc1();
    fw_upd_req = 1'b0;
    uc_rst_b = 1'b0;
    repeat (3) cyc1();
    uc_rst_b = 1'b1;
    chk("fwu_count_before", 32'(fw_upd_count), 0);
    cyc1();
    chk("fwu_count", 32'(fw_upd_count), 1);
    chk("fwu_run_busy", 32'(busy), 0);
    repeat (5) cyc1();
    chk("fwu_count_hold", 32'(fw_upd_count), 1);
    uc_rst_b = 1'b0;
    apply_reset();
    brkpt_en = 1'b1;
    stall_max = 5;
    push_stream(NW);
    push_wr(A_DONE, 32'h1);
    pulse_rff();
    wait_drain("drain_brk", 200);
    cyc1();
    for (int i = 0; i < 50; i++) begin
      chk("brk_busy", 32'(busy), 1);
      chk("brk_wr_req", 32'(wr_req), 0);
      cyc1();
    end
    push_wr(A_CONT, 32'h1);
    continue_req = 1'b1;
    cyc1();
    continue_req = 1'b0;
    wait_drain("drain_cont", 20);
    cyc1();
    chk("cont_boot_done_early", 32'(boot_done), 0);
    uc_rst_b = 1'b1;
    cyc1();
    chk("cont_boot_done", 32'(boot_done), 1);
    chk("cont_err", 32'(err), 0);
    brkpt_en = 1'b0;
    uc_rst_b = 1'b0;
    apply_reset();
    stall_max = 0;
    err_at = 3;
    push_stream(3);
    pulse_rff();
    wait_drain("drain_err", 40);
    repeat (3) cyc1();
    chk("slverr_err", 32'(err), 1);
    chk("slverr_code", 32'(err_code), 1);
    chk("slverr_wr_req", 32'(wr_req), 0);
    chk("slverr_busy", 32'(busy), 0);
    chk("slverr_boot_done", 32'(boot_done), 0);
    repeat (5) cyc1();
    err_at = 0;
    apply_reset();
    no_ack = 1'b1;
    push_wr(A_BASE, 32'hA0);
    pulse_rff();
    cyc1();
    chk("tmo_wr_req", 32'(wr_req), 1);
    count_to_err("ack_timeout_cycles", TO);
    chk("tmo_code", 32'(err_code), 2);
    chk("tmo_wr_req_off", 32'(wr_req), 0);
    no_ack = 1'b0;
    apply_reset();
    stall_max = 2;
    push_stream(NW);
    push_wr(A_DONE, 32'h1);
    ready_for_fuses = 1'b1;
    for (int n = 0; n < 60 && !(src_rd_en && src_rd_idx == 2'd2); n++) cyc1();
    chk("mid_reached_word2", 32'(src_rd_en && src_rd_idx == 2'd2), 1);
    cptra_rst_b = 1'b0;
    #1;
    chk_zero("midrst");
    exp_q.delete();
    repeat (2) cyc1();
    push_stream(NW);
    push_wr(A_DONE, 32'h1);
    cptra_rst_b = 1'b1;
    wait_drain("drain_restart", 200);
    cyc1();
    count_to_err("uc_timeout_cycles", TO);
    chk("uc_tmo_code", 32'(err_code), 3);
    chk("uc_tmo_boot_done", 32'(boot_done), 0);
    ready_for_fuses = 1'b0;
    repeat (3) cyc1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
